// File: rtl/sll32_iter_if.sv
// Start/done handshake bundle for the iterative 32-bit left shifter.
// The master issues operand and shift amount; the slave returns the result and status.
interface sll32_iter_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [SHW-1:0]   shift;
  logic [WIDTH-1:0] res;
  logic             busy;
  logic             done;

  modport master (
    output start,
    output A,
    output shift,
    input  res,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  A,
    input  shift,
    output res,
    output busy,
    output done
  );
endinterface

// File: rtl/sll32_iter.sv
// Iterative logical left shifter: one bit position per clock, start/done handshake.
// The result register doubles as the working register while shifting.
module sll32_iter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  sll32_iter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] work_reg;
  logic [SHW-1:0]   cnt_reg;
  logic             busy_reg;
  logic             done_reg;

  // busy/done are registered alongside the state so they always match it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      work_reg  <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (bus.start) begin
            work_reg <= bus.A;
            cnt_reg  <= bus.shift;
            if (bus.shift == '0) begin
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= SHIFT;
              busy_reg  <= 1'b1;
              done_reg  <= 1'b0;
            end
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
          end
        end

        SHIFT: begin
          // start is deliberately ignored here; operands are not re-captured.
          work_reg <= {work_reg[WIDTH-2:0], 1'b0};
          cnt_reg  <= cnt_reg - 1'b1;
          if (cnt_reg == SHW'(1)) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            state_reg <= SHIFT;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
          end
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.res  = work_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;

endmodule

// File: tb/tb_sll32_iter.sv
// Directed and random checks for sll32_iter; C0 is the cycle in which start is sampled.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sll32_iter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sll32_iter_if #(.WIDTH(32), .SHW(5)) bus ();

  sll32_iter #(.WIDTH(32), .SHW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] a_val;
    logic [4:0]  sh_val;
    logic [31:0] exp_val;
    int          cyc;
    int          pulses;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.shift = '0;
    #1 rst_n  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_res", bus.res, 32'h0);
    chk("reset_busy", {31'b0, bus.busy}, 32'h0);
    chk("reset_done", {31'b0, bus.done}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero shift: done in C1, busy never high
    bus.start = 1'b1; bus.A = 32'h1234_5678; bus.shift = 5'd0;
    @(negedge clk);
    bus.start = 1'b0; bus.A = 32'hFFFF_FFFF; bus.shift = 5'd7;
    chk("zero_done_c1", {31'b0, bus.done}, 32'h1);
    chk("zero_busy_c1", {31'b0, bus.busy}, 32'h0);
    chk("zero_res_c1", bus.res, 32'h1234_5678);
    @(negedge clk);
    chk("zero_done_c2", {31'b0, bus.done}, 32'h0);
    chk("zero_res_hold", bus.res, 32'h1234_5678);

    // Typical shift: A=0xF1, shift=4
    bus.start = 1'b1; bus.A = 32'h0000_00F1; bus.shift = 5'd4;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      chk($sformatf("typ_busy_c%0d", k), {31'b0, bus.busy}, 32'h1);
      chk($sformatf("typ_done_c%0d", k), {31'b0, bus.done}, 32'h0);
    end
    @(negedge clk);
    chk("typ_done_c5", {31'b0, bus.done}, 32'h1);
    chk("typ_busy_c5", {31'b0, bus.busy}, 32'h0);
    chk("typ_res_c5", bus.res, 32'h0000_0F10);

    // Maximum shift: A=0x80000001, shift=31
    @(negedge clk);
    bus.start = 1'b1; bus.A = 32'h8000_0001; bus.shift = 5'd31;
    pulses = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) pulses++;
    end
    chk("max_early_done", pulses, 0);
    @(negedge clk);
    chk("max_res_c31", bus.res, 32'h4000_0000);
    chk("max_busy_c31", {31'b0, bus.busy}, 32'h1);
    @(negedge clk);
    chk("max_done_c32", {31'b0, bus.done}, 32'h1);
    chk("max_res_c32", bus.res, 32'h8000_0000);

    // Ignored start during SHIFT
    @(negedge clk);
    bus.start = 1'b1; bus.A = 32'h0000_0001; bus.shift = 5'd8;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.A = 32'hDEAD_BEEF; bus.shift = 5'd1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("ign_busy_c4", {31'b0, bus.busy}, 32'h1);
    repeat (4) @(negedge clk);
    chk("ign_done_c8", {31'b0, bus.done}, 32'h0);
    chk("ign_busy_c8", {31'b0, bus.busy}, 32'h1);
    @(negedge clk);
    chk("ign_done_c9", {31'b0, bus.done}, 32'h1);
    chk("ign_res_c9", bus.res, 32'h0000_0100);

    // Back-to-back with start held high
    @(negedge clk);
    bus.start = 1'b1; bus.A = 32'h0000_0003; bus.shift = 5'd2;
    @(negedge clk);
    chk("b2b_busy_c1", {31'b0, bus.busy}, 32'h1);
    @(negedge clk);
    chk("b2b_busy_c2", {31'b0, bus.busy}, 32'h1);
    @(negedge clk);
    chk("b2b_done_c3", {31'b0, bus.done}, 32'h1);
    chk("b2b_res_c3", bus.res, 32'h0000_000C);
    bus.A = 32'h0000_0005; bus.shift = 5'd1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_busy_c4", {31'b0, bus.busy}, 32'h1);
    chk("b2b_done_c4", {31'b0, bus.done}, 32'h0);
    @(negedge clk);
    chk("b2b_done_c5", {31'b0, bus.done}, 32'h1);
    chk("b2b_res_c5", bus.res, 32'h0000_000A);

    // Reset mid-SHIFT aborts the operation
    @(negedge clk);
    bus.start = 1'b1; bus.A = 32'hFFFF_FFFF; bus.shift = 5'd20;
    repeat (5) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("abort_res_before", bus.res, 32'hFFFF_FFF0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_res", bus.res, 32'h0);
    chk("abort_busy", {31'b0, bus.busy}, 32'h0);
    chk("abort_done", {31'b0, bus.done}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done || bus.busy) pulses++;
    end
    chk("abort_no_done", pulses, 0);

    // Random compare against A << shift, with latency check
    for (int i = 0; i < 1000; i++) begin
      a_val   = $urandom;
      sh_val  = 5'($urandom_range(0, 31));
      exp_val = a_val << sh_val;
      bus.start = 1'b1; bus.A = a_val; bus.shift = sh_val;
      cyc = 0;
      do begin
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = $urandom;
        bus.shift = 5'($urandom_range(0, 31));
        cyc++;
      end while (!bus.done && cyc < 40);
      chk($sformatf("rnd%0d_done", i), {31'b0, bus.done}, 32'h1);
      chk($sformatf("rnd%0d_lat", i), cyc, 32'(sh_val) + 32'd1);
      chk($sformatf("rnd%0d_res", i), bus.res, exp_val);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
